// File: rtl/or3_sweep_ctrl.sv
// Sweep controller for a 3-input gate: steps {a,b,c} through 0..7, holds each
// vector for DWELL cycles, captures d/e per vector and grades against expected maps.
module or3_sweep_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_d,
  input  logic [7:0] exp_e,
  input  logic       d,
  input  logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [7:0] d_map,
  output logic [7:0] e_map,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(DWELL - 1);

  state_t     state_r, state_s;
  logic [2:0] vec_r, vec_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] d_map_r, d_map_s;
  logic [7:0] e_map_r, e_map_s;
  logic [2:0] abc_r, abc_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       pass_r, pass_s;

  // Next-state, capture and grading logic; abort takes priority over capture.
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    cnt_s   = cnt_r;
    d_map_s = d_map_r;
    e_map_s = e_map_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          vec_s   = 3'd0;
          cnt_s   = CNT_RELOAD;
          d_map_s = 8'h00;
          e_map_s = 8'h00;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
          vec_s   = 3'd0;
          cnt_s   = 8'd0;
        end else if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else begin
          d_map_s[vec_r] = d;
          e_map_s[vec_r] = e;
          if (vec_r != 3'd7) begin
            vec_s = vec_r + 3'd1;
            cnt_s = CNT_RELOAD;
          end else begin
            // Grade against the maps including the vector-7 bits captured now.
            state_s = ST_IDLE;
            vec_s   = 3'd0;
            done_s  = 1'b1;
            pass_s  = (d_map_s == exp_d) && (e_map_s == exp_e);
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        vec_s   = 3'd0;
        cnt_s   = 8'd0;
      end
    endcase
    busy_s = (state_s == ST_RUN);
    if (busy_s) begin
      abc_s = vec_s;
    end else begin
      abc_s = 3'b000;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      vec_r   <= 3'd0;
      cnt_r   <= 8'd0;
      d_map_r <= 8'h00;
      e_map_r <= 8'h00;
      abc_r   <= 3'b000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      cnt_r   <= cnt_s;
      d_map_r <= d_map_s;
      e_map_r <= e_map_s;
      abc_r   <= abc_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign a     = abc_r[2];
  assign b     = abc_r[1];
  assign c     = abc_r[0];
  assign d_map = d_map_r;
  assign e_map = e_map_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign pass  = pass_r;

endmodule

// File: tb/tb_or3_sweep_ctrl.sv
// Directed bench for or3_sweep_ctrl: an OR3 gate model closes the loop, expected
// sweep results are queued at start and compared when done pulses.
module tb_or3_sweep_ctrl;

  typedef struct packed {
    logic [7:0] dm;
    logic [7:0] em;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start4, abort4, d_stuck;
  logic [7:0] exp_d4, exp_e4;
  logic       d4, e4, a4, b4, c4, busy4, done4, pass4;
  logic [7:0] d_map4, e_map4;
  logic       start1, abort1;
  logic [7:0] exp_d1, exp_e1;
  logic       d1, e1, a1, b1, c1, busy1, done1, pass1;
  logic [7:0] d_map1, e_map1;

  exp_t q4[$];
  exp_t q1[$];
  int   n_vec;
  int   n_err;
  int   k;

  assign d4 = d_stuck ? 1'b0 : (a4 | b4 | c4);
  assign e4 = ~(a4 | b4 | c4);
  assign d1 = a1 | b1 | c1;
  assign e1 = ~(a1 | b1 | c1);

  or3_sweep_ctrl #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .exp_d(exp_d4), .exp_e(exp_e4), .d(d4), .e(e4),
    .a(a4), .b(b4), .c(c4), .d_map(d_map4), .e_map(e_map4),
    .busy(busy4), .done(done4), .pass(pass4)
  );

  or3_sweep_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .exp_d(exp_d1), .exp_e(exp_e1), .d(d1), .e(e1),
    .a(a1), .b(b1), .c(c1), .d_map(d_map1), .e_map(e_map1),
    .busy(busy1), .done(done1), .pass(pass1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check4();
    exp_t x;
    if (q4.size() == 0) begin
      check("sb4_empty", 32'd0, 32'd1);
    end else begin
      x = q4.pop_front();
      check("d_map4", {24'd0, d_map4}, {24'd0, x.dm});
      check("e_map4", {24'd0, e_map4}, {24'd0, x.em});
      check("pass4", {31'd0, pass4}, {31'd0, x.p});
    end
  endtask

  // Assumes start4 was raised before the last rising edge; returns edges to done.
  task automatic wait_done4(input int drop_at, output int kk);
    kk = 0;
    @(negedge clk);
    while (kk < 40 && done4 !== 1'b1) begin
      if (kk == drop_at) start4 = 1'b0;
      if (kk < 32) begin
        check("abc4", {29'd0, a4, b4, c4}, 32'(kk / 4));
        check("busy4", {31'd0, busy4}, 32'd1);
      end
      @(negedge clk);
      kk++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start4 = 1'b0; abort4 = 1'b0; d_stuck = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    exp_d4 = 8'hFE; exp_e4 = 8'h01; exp_d1 = 8'hFE; exp_e1 = 8'h01;

    // reset state
    @(negedge clk);
    check("rst_abc4", {29'd0, a4, b4, c4}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_pass4", {31'd0, pass4}, 32'd0);
    check("rst_map4", {16'd0, d_map4, e_map4}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // d stuck at 0
    d_stuck = 1'b1;
    q4.push_back('{dm: 8'h00, em: 8'h01, p: 1'b0});
    start4 = 1'b1;
    wait_done4(0, k);
    check("done_lat_stuck", 32'(k), 32'd32);
    sb_check4();
    @(negedge clk);
    check("done_1cyc", {31'd0, done4}, 32'd0);
    d_stuck = 1'b0;

    // good gate
    q4.push_back('{dm: 8'hFE, em: 8'h01, p: 1'b1});
    start4 = 1'b1;
    wait_done4(0, k);
    check("done_lat_good", 32'(k), 32'd32);
    check("busy_at_done", {31'd0, busy4}, 32'd0);
    sb_check4();
    @(negedge clk);

    // abort in cycle 10
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_abc", {29'd0, a4, b4, c4}, 32'd0);
    check("abort_dmap", {24'd0, d_map4}, 32'h02);
    check("abort_emap", {24'd0, e_map4}, 32'h01);
    check("abort_pass", {31'd0, pass4}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      check("abort_no_done", {31'd0, done4}, 32'd0);
      @(negedge clk);
    end

    // abort in idle
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", {31'd0, busy4}, 32'd0);
    check("idle_abort_dmap", {24'd0, d_map4}, 32'h02);

    // abort coinciding with capture edge
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort0_busy", {31'd0, busy4}, 32'd0);
    check("abort0_nocap", {16'd0, d_map4, e_map4}, 32'd0);
    check("abort0_done", {31'd0, done4}, 32'd0);
    check("abort0_pass", {31'd0, pass4}, 32'd1);
    @(negedge clk);

    // start held for 40 cycles: back-to-back sweeps
    q4.push_back('{dm: 8'hFE, em: 8'h01, p: 1'b1});
    q4.push_back('{dm: 8'hFE, em: 8'h01, p: 1'b1});
    start4 = 1'b1;
    wait_done4(-1, k);
    check("held_lat1", 32'(k), 32'd32);
    sb_check4();
    wait_done4(6, k);
    check("held_lat2", 32'(k), 32'd32);
    sb_check4();
    @(negedge clk);
    check("held_no_third", {31'd0, busy4}, 32'd0);

    // asynchronous reset mid-sweep
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_abc", {29'd0, a4, b4, c4}, 32'd0);
    check("arst_busy", {31'd0, busy4}, 32'd0);
    check("arst_dmap", {24'd0, d_map4}, 32'd0);
    check("arst_pass", {31'd0, pass4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check("arst_no_done", {31'd0, done4}, 32'd0);
      @(negedge clk);
    end

    // DWELL=1 sweep after reset
    q1.push_back('{dm: 8'hFE, em: 8'h01, p: 1'b1});
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (k < 20 && done1 !== 1'b1) begin
      if (k < 8) check("abc1", {29'd0, a1, b1, c1}, 32'(k));
      @(negedge clk);
      k++;
    end
    check("d1_lat", 32'(k), 32'd8);
    if (q1.size() == 0) begin
      check("sb1_empty", 32'd0, 32'd1);
    end else begin
      exp_t x;
      x = q1.pop_front();
      check("d_map1", {24'd0, d_map1}, {24'd0, x.dm});
      check("e_map1", {24'd0, e_map1}, {24'd0, x.em});
      check("pass1", {31'd0, pass1}, {31'd0, x.p});
    end
    check("sb4_left", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
